// File: rtl/test_i10913.sv
// Gated 4-state sequencer with registered output; define
// TEST_I10913_INPUT_BYPASS_EN to drop the input register stage.
module test_i10913 #(
  parameter logic OUT_RESET_VAL = 1'b0
) (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic N4,
  input  logic CK,
  input  logic reset,
  output logic out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [4:0] n_cur;
  logic       g;
  logic       out_d;

`ifdef TEST_I10913_INPUT_BYPASS_EN
  assign n_cur = {N4, N3, N2, N1, N0};
`else
  logic [4:0] n_q;

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      n_q <= 5'b00000;
    end else begin
      n_q <= {N4, N3, N2, N1, N0};
    end
  end

  assign n_cur = n_q;
`endif

  assign g = ~(n_cur[0] & n_cur[1])
           ^ ~(n_cur[2] | n_cur[3]);

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state <= S0;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = S0;
    unique case (state)
      S0: state_nx = g ? S1 : S0;
      S1: state_nx = g ? S2 : S0;
      S2: begin
        if (!g) begin
          state_nx = S0;
        end else if (n_cur[4]) begin
          state_nx = S3;
        end else begin
          state_nx = S2;
        end
      end
      S3: state_nx = S0;
    endcase
  end

  // output uses the state before the edge
  always_comb begin
    out_d = g ^ (state == S3);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      out <= OUT_RESET_VAL;
    end else begin
      out <= out_d;
    end
  end

endmodule

// File: tb/tb_test_i10913.sv
// Directed bench for test_i10913; honours
// TEST_I10913_INPUT_BYPASS_EN to shift expected tables one edge.
module tb_test_i10913;

`ifdef TEST_I10913_INPUT_BYPASS_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic N0, N1, N2, N3, N4;
  logic CK;
  logic reset;
  logic out;

  int n_run  = 0;
  int n_fail = 0;

  test_i10913 #(.OUT_RESET_VAL(1'b0)) dut (
    .N0    (N0),
    .N1    (N1),
    .N2    (N2),
    .N3    (N3),
    .N4    (N4),
    .CK    (CK),
    .reset (reset),
    .out   (out)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_n(input logic [4:0] v);
    {N4, N3, N2, N1, N0} = v;
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  function automatic logic [7:0] st();
    return {6'b0, dut.state};
  endfunction

  // reset pulse between edges: must act at once
  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_rst_out"}, {7'b0, out}, 8'h00);
    check({tag, "_rst_st"}, st(), 8'h00);
    #2;
    reset = 1'b1;
  endtask

  task automatic run_seq(input string tag,
                         input int n,
                         input logic [1:0] es [0:9],
                         input logic eo [0:9]);
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s_out%0d", tag, k + 1),
            {7'b0, out}, {7'b0, eo[k + SKIP]});
      check($sformatf("%s_st%0d", tag, k + 1),
            st(), {6'b0, es[k + SKIP]});
    end
  endtask

  logic [1:0] sa [0:9] = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2};
  logic       oa [0:9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  logic [1:0] sb [0:9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
  logic       ob [0:9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 1};

  logic [4:0] gv [0:5] = '{5'b00001, 5'b00100, 5'b01000,
                           5'b01111, 5'b00010, 5'b00011};
  logic       ge [0:5] = '{0, 1, 1, 0, 0, 1};

  initial begin
    reset = 1'b0;
    set_n(5'b00000);

    // held in reset with clock and random inputs
    for (int i = 0; i < 4; i++) begin
      set_n(5'($urandom));
      tick();
      check($sformatf("hold_out%0d", i), {7'b0, out}, 8'h00);
      check($sformatf("hold_st%0d", i), st(), 8'h00);
    end

    set_n(5'b00000);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("zero_out%0d", i), {7'b0, out}, 8'h00);
      check($sformatf("zero_st%0d", i), st(), 8'h00);
    end

    set_n(5'b00011);
    run_seq("seqa", 6, sa, oa);

    pulse_reset("midS2");
    run_seq("seqa2", 6, sa, oa);

    pulse_reset("preB");
    set_n(5'b10011);
    run_seq("seqb", 8, sb, ob);

    for (int i = 0; i < 6; i++) begin
      pulse_reset($sformatf("gv%0d", i));
      set_n(gv[i]);
      tick();
      tick();
      check($sformatf("g_vec%0d", i), {7'b0, out}, {7'b0, ge[i]});
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
